// File: rtl/set_bit_pkg.sv
// ============================================================================
//  Module      : set_bit_pkg
//  Description : Shared defaults and state encoding for set_bit_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package set_bit_pkg;

    localparam int c_WIDTH_DEF = 32;
    localparam int c_IDX_W_DEF = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lsb_finder.sv
// ============================================================================
//  Module      : lsb_finder
//  Description : Combinational lowest-set-bit detector (mask, index, single).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsb_finder
    import set_bit_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF,
    parameter int IDX_W = c_IDX_W_DEF
) (
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] mask,
    output logic [IDX_W-1:0] index,
    output logic             single
);

    logic [WIDTH-1:0] w_mask;
    logic [IDX_W-1:0] w_index;

    assign w_mask = word & (~word + WIDTH'(1));

    // The mask is one-hot, so OR-ing the positions of its set bits yields the index.
    always_comb begin
        w_index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_mask[i]) begin
                w_index = w_index | IDX_W'(i);
            end
        end
    end

    assign mask   = w_mask;
    assign index  = w_index;
    assign single = (word != '0) && ((word & (word - WIDTH'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/set_bit_serializer.sv
// ============================================================================
//  Module      : set_bit_serializer
//  Description : Splits each accepted word into one beat per set bit, LSB first.
//                Optional popcount output enabled by SET_BIT_SERIALIZER_POPCOUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module set_bit_serializer
    import set_bit_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF,
    parameter int IDX_W = c_IDX_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [WIDTH-1:0] out_mask,
    output logic             out_last
`ifdef SET_BIT_SERIALIZER_POPCOUNT_EN
    ,
    output logic [IDX_W:0]   out_count
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_residual;
    logic [WIDTH-1:0] w_residual_nxt;

    logic [WIDTH-1:0] w_mask;
    logic [IDX_W-1:0] w_index;
    logic             w_single;
    logic             w_scan;
    logic             w_fire;
    logic             w_last_fire;
    logic             w_accept;

    lsb_finder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_lsb_finder (
        .word   (r_residual),
        .mask   (w_mask),
        .index  (w_index),
        .single (w_single)
    );

    assign w_scan      = (r_state == ST_SCAN);
    assign w_fire      = w_scan && out_ready;
    assign w_last_fire = w_fire && w_single;
    assign in_ready    = !w_scan || w_last_fire;
    assign w_accept    = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_residual <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_residual <= w_residual_nxt;
        end
    end

    // A new word only loads when the previous one is fully drained, so the
    // residual is replaced, never merged.
    always_comb begin
        w_state_nxt    = r_state;
        w_residual_nxt = r_residual;
        if (w_accept) begin
            w_residual_nxt = in_word;
            w_state_nxt    = (in_word != '0) ? ST_SCAN : ST_IDLE;
        end else if (w_fire) begin
            w_residual_nxt = r_residual & ~w_mask;
            if (w_single) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    assign out_valid = w_scan;
    assign out_mask  = w_scan ? w_mask  : '0;
    assign out_index = w_scan ? w_index : '0;
    assign out_last  = w_scan && w_single;

`ifdef SET_BIT_SERIALIZER_POPCOUNT_EN
    logic [IDX_W:0] r_count;
    logic [IDX_W:0] w_pop;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + {{IDX_W{1'b0}}, in_word[i]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= w_pop;
        end else if (w_last_fire) begin
            r_count <= '0;
        end
    end

    assign out_count = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_set_bit_serializer.sv
// ============================================================================
//  Module      : tb_set_bit_serializer
//  Description : Self-checking bench for set_bit_serializer against a
//                queue-of-indices reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_set_bit_serializer;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_word;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [WIDTH-1:0] out_mask;
    logic             out_last;
`ifdef SET_BIT_SERIALIZER_POPCOUNT_EN
    logic [IDX_W:0]   out_count;
`endif

    int nchk = 0;
    int nerr = 0;

    // Reference model: remaining set-bit positions of the current word.
    int q[$];
    int cur_pop = 0;

    set_bit_serializer #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_mask  (out_mask),
        .out_last  (out_last)
`ifdef SET_BIT_SERIALIZER_POPCOUNT_EN
        ,
        .out_count (out_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_load(input logic [WIDTH-1:0] w);
        q.delete();
        for (int i = 0; i < WIDTH; i++) begin
            if (((w >> i) & 32'd1) != 0) q.push_back(i);
        end
        cur_pop = q.size();
    endtask

    task automatic check_outputs(input string tag);
        logic          e_valid;
        logic          e_last;
        logic          e_ready;
        logic [31:0]   e_idx;
        logic [31:0]   e_mask;
        e_valid = (q.size() > 0);
        e_idx   = e_valid ? 32'(q[0]) : 32'd0;
        e_mask  = e_valid ? (32'd1 << q[0]) : 32'd0;
        e_last  = (q.size() == 1);
        e_ready = (q.size() == 0) || (out_ready && q.size() == 1);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
        check({tag, ".in_ready"},  64'(in_ready),  64'(e_ready));
        check({tag, ".out_index"}, 64'(out_index), 64'(e_idx));
        check({tag, ".out_mask"},  64'(out_mask),  64'(e_mask));
        check({tag, ".out_last"},  64'(out_last),  64'(e_last));
`ifdef SET_BIT_SERIALIZER_POPCOUNT_EN
        check({tag, ".out_count"}, 64'(out_count), e_valid ? 64'(cur_pop) : 64'd0);
`endif
    endtask

    // One clock cycle: drive, check against the model, clock, advance the model.
    task automatic step(input string tag, input logic iv, input logic [WIDTH-1:0] iw, input logic ordy);
        logic fire;
        logic acc;
        in_valid  = iv;
        in_word   = iw;
        out_ready = ordy;
        #1;
        check_outputs(tag);
        fire = (q.size() > 0) && ordy;
        acc  = iv && ((q.size() == 0) || (fire && q.size() == 1));
        @(posedge clock);
        if (fire) void'(q.pop_front());
        if (acc) model_load(iw);
        @(negedge clock);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("reset.in_ready",  64'(in_ready),  64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.out_index", 64'(out_index), 64'd0);
        check("reset.out_mask",  64'(out_mask),  64'd0);
        check("reset.out_last",  64'(out_last),  64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Two set bits, always-ready sink
        step("w5.acc", 1'b1, 32'h0000_0005, 1'b1);
        step("w5.b0",  1'b0, 32'h0,         1'b1);
        #1;
        check("w5.last_idx", 64'(out_index), 64'd2);
        check("w5.last_ready", 64'(in_ready), 64'd1);
        step("w5.b1",  1'b0, 32'h0,         1'b1);
        step("w5.idle", 1'b0, 32'h0,        1'b1);

        // Back-pressure holds the presented beat
        step("w81.acc", 1'b1, 32'h8000_0001, 1'b0);
        for (int i = 0; i < 3; i++) step("w81.stall", 1'b0, 32'h0, 1'b0);
        step("w81.b0", 1'b0, 32'h0, 1'b1);
        #1;
        check("w81.idx31", 64'(out_index), 64'd31);
        check("w81.last",  64'(out_last),  64'd1);
        step("w81.b1", 1'b0, 32'h0, 1'b1);

        // Zero word is swallowed
        step("w0.acc",  1'b1, 32'h0, 1'b1);
        step("w0.after", 1'b0, 32'h0, 1'b1);

        // Back-to-back words, no bubble
        step("bb.acc3",  1'b1, 32'h0000_0003, 1'b1);
        step("bb.b0",    1'b1, 32'h0000_0010, 1'b1);
        step("bb.b1",    1'b1, 32'h0000_0010, 1'b1);
        #1;
        check("bb.idx4", 64'(out_index), 64'd4);
        step("bb.b4",    1'b0, 32'h0, 1'b1);
        step("bb.idle",  1'b0, 32'h0, 1'b1);

        // Asynchronous reset mid-scan
        step("ff.acc", 1'b1, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 10; i++) step("ff.beat", 1'b0, 32'h0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ff.rst_valid", 64'(out_valid), 64'd0);
        check("ff.rst_ready", 64'(in_ready),  64'd1);
        check("ff.rst_mask",  64'(out_mask),  64'd0);
        q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        step("r100.acc", 1'b1, 32'h0000_0100, 1'b1);
        #1;
        check("r100.idx8", 64'(out_index), 64'd8);
        check("r100.last", 64'(out_last),  64'd1);
        step("r100.b8",   1'b0, 32'h0, 1'b1);
        step("r100.idle", 1'b0, 32'h0, 1'b1);

`ifdef SET_BIT_SERIALIZER_POPCOUNT_EN
        step("pc.acc", 1'b1, 32'h0000_F00F, 1'b1);
        for (int i = 0; i < 8; i++) step("pc.beat", 1'b0, 32'h0, 1'b1);
        step("pc.idle", 1'b0, 32'h0, 1'b1);
`endif

        // Random traffic with sparse, dense and zero words
        for (int n = 0; n < 400; n++) begin
            logic [WIDTH-1:0] w;
            case ($urandom_range(0, 3))
                0:       w = '0;
                1:       w = $urandom & $urandom & $urandom;
                default: w = $urandom;
            endcase
            step("rand", 1'($urandom_range(0, 1)), w, ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
